// File: rtl/uart_rx_sampler.sv
// 16x-oversampling 8N1 UART receiver with a first-word-fall-through byte FIFO.
// Bytes with a bad stop bit are dropped and reported through frame_err.
module uart_rx_sampler #(
    parameter int DEPTH = 4
) (
    input  logic       reset,
    input  logic       clk16,
    input  logic       rx_in,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_done,
    output logic       frame_err,
    output logic       overrun,
    output logic [2:0] fifo_count
);

    localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] FULL_COUNT = 3'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic       sync1_q, sync2_q;
    logic       rx_s;
    logic       push_req;
    logic       ferr_req;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0]    count_q;
    logic          done_q, ferr_q, overrun_q;
    logic          full, do_pop, do_push, new_overrun;

    // Synchronizer flops reset high so an idle line never looks like a start bit.
    always_ff @(posedge clk16 or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    always_ff @(posedge clk16 or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // cnt wraps 15 -> 0 inside DATA, giving one sample every 16 ticks.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        ferr_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == 4'd7) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        cnt_d   = '0;
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_req = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign full        = (count_q == FULL_COUNT);
    assign do_pop      = rd_en && (count_q != 3'd0);
    assign do_push     = push_req && (!full || do_pop);
    assign new_overrun = push_req && full && !do_pop;

    always_ff @(posedge clk16 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 3'd1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 3'd1;
            end
            done_q <= do_push;
            ferr_q <= ferr_req;
            if (new_overrun) begin
                overrun_q <= 1'b1;
            end else if (rd_en) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rx_data    = mem_q[rd_ptr_q];
    assign rx_valid   = (count_q != 3'd0);
    assign rx_done    = done_q;
    assign frame_err  = ferr_q;
    assign overrun    = overrun_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed frames plus randomized traffic,
// compared against a queue-based model of the received-byte FIFO.
module tb_uart_rx_sampler;

    localparam int DEPTH = 4;

    logic       reset;
    logic       clk16;
    logic       rxIn;
    logic       rdEn;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxDone;
    logic       frameErr;
    logic       overrun;
    logic [2:0] fifoCount;

    int         checks   = 0;
    int         failures = 0;
    int         doneSeen = 0;
    int         ferrSeen = 0;
    int         expDone  = 0;
    int         expFerr  = 0;
    logic [7:0] modelQ[$];
    logic       modelOvr = 1'b0;

    uart_rx_sampler #(.DEPTH(DEPTH)) dut (
        .reset      (reset),
        .clk16      (clk16),
        .rx_in      (rxIn),
        .rd_en      (rdEn),
        .rx_data    (rxData),
        .rx_valid   (rxValid),
        .rx_done    (rxDone),
        .frame_err  (frameErr),
        .overrun    (overrun),
        .fifo_count (fifoCount)
    );

    initial clk16 = 1'b0;
    always #5 clk16 = ~clk16;

    always @(negedge clk16) begin
        if (reset) begin
            if (rxDone)   doneSeen++;
            if (frameErr) ferrSeen++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkModel(input string where);
        checkOutput({where, " fifo_count"}, 32'(fifoCount), modelQ.size());
        checkOutput({where, " rx_valid"}, 32'(rxValid), 32'(modelQ.size() != 0));
        checkOutput({where, " overrun"}, 32'(overrun), 32'(modelOvr));
        if (modelQ.size() != 0) begin
            checkOutput({where, " rx_data"}, 32'(rxData), 32'(modelQ[0]));
        end
        checkOutput({where, " rx_done_pulses"}, doneSeen, expDone);
        checkOutput({where, " frame_err_pulses"}, ferrSeen, expFerr);
    endtask

    // One 8N1 frame, 16 ticks per bit; popAt raises rd_en on the stop-sample tick.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input logic popAt,
                                 input int holdLow, input int gap);
        int   sizeBefore;
        logic popped;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk16);
            if (c < 16)       rxIn = 1'b0;
            else if (c < 144) rxIn = b[(c - 16) / 16];
            else              rxIn = stopBit;
            rdEn = popAt && (c == 154);
            if (popAt && (c == 154) && (modelQ.size() != 0)) begin
                checkOutput("head_at_concurrent_pop", 32'(rxData), 32'(modelQ[0]));
            end
        end
        sizeBefore = modelQ.size();
        popped     = popAt && (sizeBefore != 0);
        if (popped) void'(modelQ.pop_front());
        if (stopBit) begin
            if ((sizeBefore < DEPTH) || popped) begin
                modelQ.push_back(b);
                expDone++;
            end
        end else begin
            expFerr++;
        end
        if (stopBit && (sizeBefore == DEPTH) && !popped) modelOvr = 1'b1;
        else if (popAt)                                   modelOvr = 1'b0;
        repeat (holdLow) @(negedge clk16);
        @(negedge clk16);
        rxIn = 1'b1;
        repeat (gap) @(negedge clk16);
    endtask

    task automatic popOne();
        logic nonEmpty;
        @(negedge clk16);
        nonEmpty = (modelQ.size() != 0);
        checkOutput("valid_before_pop", 32'(rxValid), 32'(nonEmpty));
        if (nonEmpty) checkOutput("data_before_pop", 32'(rxData), 32'(modelQ[0]));
        rdEn = 1'b1;
        @(negedge clk16);
        rdEn = 1'b0;
        if (nonEmpty) void'(modelQ.pop_front());
        modelOvr = 1'b0;
    endtask

    task automatic checkResetState(input string where);
        checkOutput({where, " rx_valid"}, 32'(rxValid), 0);
        checkOutput({where, " fifo_count"}, 32'(fifoCount), 0);
        checkOutput({where, " rx_data"}, 32'(rxData), 0);
        checkOutput({where, " overrun"}, 32'(overrun), 0);
        checkOutput({where, " rx_done"}, 32'(rxDone), 0);
        checkOutput({where, " frame_err"}, 32'(frameErr), 0);
    endtask

    initial begin
        #5_000_000;
        failures++;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [7:0] partial;
        int         nPops;

        reset = 1'b0;
        rxIn  = 1'b1;
        rdEn  = 1'b0;
        repeat (3) @(negedge clk16);
        checkResetState("reset");
        reset = 1'b1;
        repeat (5) @(negedge clk16);

        applyStimulus(8'hA5, 1'b1, 1'b0, 0, 8);
        checkModel("a5");
        checkOutput("a5 data", 32'(rxData), 32'h0A5);
        checkOutput("a5 count", 32'(fifoCount), 1);
        popOne();
        checkModel("a5 popped");

        // Short low glitch must be rejected at the start-bit mid-check.
        @(negedge clk16);
        rxIn = 1'b0;
        repeat (5) @(negedge clk16);
        rxIn = 1'b1;
        repeat (40) @(negedge clk16);
        checkModel("glitch");
        applyStimulus(8'h3C, 1'b1, 1'b0, 0, 8);
        checkModel("after glitch");
        popOne();

        applyStimulus(8'h55, 1'b0, 1'b0, 640, 8);
        checkModel("break");
        checkOutput("break ferr count", ferrSeen, 1);
        applyStimulus(8'h0F, 1'b1, 1'b0, 0, 8);
        checkModel("after break");
        popOne();

        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1, 1'b0, 0, 6);
        checkModel("overrun fill");
        checkOutput("overrun set", 32'(overrun), 1);
        checkOutput("full count", 32'(fifoCount), 4);
        popOne();
        checkOutput("overrun cleared", 32'(overrun), 0);
        repeat (3) popOne();
        checkModel("overrun drained");

        for (int i = 0; i < 4; i++) applyStimulus(8'(8'h10 + i), 1'b1, 1'b0, 0, 6);
        applyStimulus(8'h77, 1'b1, 1'b1, 0, 6);
        checkModel("concurrent");
        checkOutput("concurrent no overrun", 32'(overrun), 0);
        checkOutput("concurrent count", 32'(fifoCount), 4);
        repeat (4) popOne();
        checkModel("concurrent drained");

        applyStimulus(8'h21, 1'b1, 1'b0, 0, 6);
        partial = 8'h99;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk16);
            rxIn = (c < 16) ? 1'b0 : partial[(c - 16) / 16];
        end
        @(negedge clk16);
        reset = 1'b0;
        rxIn  = 1'b1;
        repeat (3) @(negedge clk16);
        checkResetState("midframe reset");
        modelQ.delete();
        modelOvr = 1'b0;
        reset    = 1'b1;
        repeat (4) @(negedge clk16);
        applyStimulus(8'hC3, 1'b1, 1'b0, 0, 6);
        checkModel("after reset");
        checkOutput("after reset data", 32'(rxData), 32'h0C3);
        checkOutput("after reset count", 32'(fifoCount), 1);
        popOne();

        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                          0, $urandom_range(4, 30));
            checkModel("random");
            nPops = (i < 20) ? $urandom_range(0, 1) : $urandom_range(0, 2);
            repeat (nPops) popOne();
        end
        checkModel("random end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 Parameter: DEPTH, default 4, receive FIFO depth in bytes (power of 2).
REQ-002 Port: reset, input, 1, asynchronous, active-low.
REQ-003 Port: clk16, input, 1, clock at 16x the baud rate; all state SHALL be updated on its rising edge.
REQ-004 Port: rx_in, input, 1, asynchronous serial line; idles high; 8N1 format, LSB first.
REQ-005 Port: rd_en, input, 1, pop request for the FIFO head.
REQ-006 Port: rx_data, output, 8, FIFO head byte, first-word-fall-through.
REQ-007 Port: rx_valid, output, 1, high while the FIFO is non-empty.
REQ-008 Port: rx_done, output, 1, one-cycle pulse when a good byte is pushed.
REQ-009 Port: frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-010 Port: overrun, output, 1, sticky flag; set when a byte is dropped because the FIFO is full.
REQ-011 Port: fifo_count, output, 3, number of bytes held, 0..DEPTH.

Function
REQ-012 rx_in SHALL pass through a 2-flop synchronizer to give rx_s; all timing below is stated in terms of rx_s.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH; a 4-bit tick counter cnt and a 3-bit bit index SHALL be used.
REQ-014 IDLE: when rx_s=0, go to START with cnt=0.
REQ-015 START: increment cnt; at cnt=7, if rx_s=1 return to IDLE (glitch, no output activity), otherwise go to DATA with cnt=0 and bit index=0.
REQ-016 DATA: increment cnt; at cnt=15, shift rx_s into bit[index] (LSB first) and advance the index; after index 7, go to STOP with cnt=0.
REQ-017 STOP: at cnt=15, sample rx_s.
REQ-018 STOP sample =1: push the byte, pulse rx_done the next cycle, go to IDLE.
REQ-019 STOP sample =0: discard the byte, pulse frame_err the next cycle, go to WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until rx_s=1, then go to IDLE; a break condition SHALL therefore yield exactly one frame_err.
REQ-021 Each data sample point SHALL be 16 clk16 cycles after the previous one; the first data sample SHALL be 16 cycles after the start-bit mid-check.
REQ-022 Push: the byte SHALL be written at the tail; rx_valid and fifo_count SHALL reflect it on the cycle after the stop sample.
REQ-023 Pop: when rd_en=1 and rx_valid=1, the head SHALL advance at the clock edge; rd_en while empty SHALL be ignored.
REQ-024 Push while full with no pop: the new byte SHALL be dropped, overrun set, and FIFO contents unchanged.
REQ-025 Push and pop in the same cycle: both SHALL occur, including when full; fifo_count SHALL be unchanged and overrun SHALL NOT be set.
REQ-026 overrun SHALL clear on the first cycle rd_en=1 in which no new overrun occurs.
REQ-027 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 fifo_count SHALL be pointer-independent and saturate at neither end beyond 0..DEPTH.
REQ-029 rx_data SHALL show the head entry while rx_valid=1; its value while empty is don't-care except after reset.

Reset
REQ-030 reset=0 SHALL immediately force: FSM to IDLE, cnt=0, index=0, pointers=0, fifo_count=0, rx_data=0, rx_valid=0, rx_done=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-031 Reset mid-frame SHALL discard the partial byte; after release, reception SHALL start only on a new falling edge of rx_s.

Verification
REQ-032 Send 0xA5 (8N1, 16 clk16 per bit) -> rx_done pulses once; rx_data=0xA5; rx_valid=1; fifo_count=1; rd_en pulse -> rx_valid=0, fifo_count=0.
REQ-033 Drive a 5-cycle low glitch on idle line -> no rx_done, no frame_err; FSM back in IDLE; next frame 0x3C received correctly.
REQ-034 Send 0x55 with stop bit=0, then hold line low 40 bit-times -> exactly one frame_err pulse; no push; after line returns high, 0x0F received correctly.
REQ-035 Send 5 bytes 0x01..0x05 without reads (DEPTH=4) -> fifo_count=4; overrun=1; reads return 0x01..0x04; overrun clears on first read.
REQ-036 With FIFO full, assert rd_en in the same cycle a new byte 0x77 is pushed -> no overrun; fifo_count stays 4; 0x77 is read last.
REQ-037 Assert reset at bit 4 of a frame, release, send 0xC3 -> only 0xC3 appears; fifo_count=1.
